active_burst_engine: RTL and testbench
======================================

ACTIVE_BURST_ENGINE -- requirements
Module: active_burst_engine

Interface
REQ-001 SHALL have parameter C_ACE_DATA_WIDTH, default 128, data-beat width in bits.
REQ-002 SHALL have parameter C_ACE_ADDR_WIDTH, default 44, address width in bits.
REQ-003 SHALL have parameter BEATS_PER_LINE, default 4, beats per cache line; power of two, 2..16.
REQ-004 SHALL have parameter MAX_LINES, default 8, maximum lines per operation.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum wait cycles in any R or B state.
REQ-006 SHALL have one clock and a synchronous, active-high reset:
- ace_aclk  in  1  clock
- ace_areset  in  1  synchronous active-high reset
REQ-007 SHALL have the following control ports (LW = C_ACE_DATA_WIDTH*BEATS_PER_LINE):
- i_start  in  1  start pulse, sampled in IDLE only
- i_mode  in  2  operation mode: 0 = read-leak, 1 = write-tamper, 2 = read-modify-write (RMW), 3 = reserved
- i_base_addr  in  C_ACE_ADDR_WIDTH  operation base address
- i_num_lines  in  clog2(MAX_LINES+1)  number of lines to process
- i_wline  in  LW  write data for mode 1
- i_xor_mask  in  LW  XOR mask for mode 2
REQ-008 SHALL have the following read-channel ports:
- o_arvalid  out  1
- o_araddr  out  C_ACE_ADDR_WIDTH
- o_arlen  out  8
- i_arready  in  1
- i_rvalid  in  1
- i_rdata  in  C_ACE_DATA_WIDTH
- i_rlast  in  1
- o_rready  out  1
- o_rack  out  1
REQ-009 SHALL have the following write-channel ports:
- o_awvalid  out  1
- o_awaddr  out  C_ACE_ADDR_WIDTH
- o_awlen  out  8
- i_awready  in  1
- o_wvalid  out  1
- o_wdata  out  C_ACE_DATA_WIDTH
- o_wlast  out  1
- i_wready  in  1
- i_bvalid  in  1
- i_bresp  in  2
- o_bready  out  1
- o_wack  out  1
REQ-010 SHALL have the following status ports:
- o_busy  out  1
- o_done  out  1  one-cycle pulse
- o_error  out  1  sticky until next start
- o_err_code  out  2  0 = none, 1 = bad RLAST, 2 = bad BRESP, 3 = timeout
- o_line  out  LW  last line read
- o_line_valid  out  1  one-cycle pulse per line read
- o_line_idx  out  clog2(MAX_LINES)  index of current line
- o_state  out  4  current FSM state

Function
REQ-011 SHALL use FSM states IDLE, LAUNCH, AR, R, RACK, MODIFY, AW, W, B, WACK, NEXT, DONE.
REQ-012 IDLE: on i_start, SHALL latch all inputs, clear o_error and o_err_code, and go to LAUNCH; i_start outside IDLE SHALL be ignored.
REQ-013 LAUNCH: if num_lines is 0, SHALL go to DONE; if mode is 3, SHALL go to DONE with no bus traffic; else mode 1 SHALL go to AW and modes 0/2 SHALL go to AR.
REQ-014 Line address SHALL be base aligned down to BYTES_PER_LINE, plus idx*BYTES_PER_LINE, where BYTES_PER_LINE = C_ACE_DATA_WIDTH/8*BEATS_PER_LINE; overflow SHALL wrap modulo 2^C_ACE_ADDR_WIDTH.
REQ-015 o_arlen and o_awlen SHALL equal BEATS_PER_LINE-1.
REQ-016 Each VALID SHALL be held high, with payload stable, until the matching READY is seen; the state SHALL advance the cycle after the handshake.
REQ-017 R: o_rready SHALL be high; beat k SHALL be stored at line slice k.
REQ-018 R: i_rlast on any beat other than BEATS_PER_LINE-1, or its absence on that beat, SHALL set err_code 1 and go to DONE.
REQ-019 RACK: o_rack SHALL be high for exactly one cycle; o_line_valid SHALL pulse in the same cycle.
REQ-020 From RACK, mode 2 SHALL go to MODIFY and mode 0 SHALL go to NEXT.
REQ-021 MODIFY: SHALL compute write line = read line XOR mask in a single cycle, then go to AW.
REQ-022 W: o_wdata SHALL be beat slice k of the write line; o_wlast SHALL be high only on beat BEATS_PER_LINE-1; the beat counter SHALL wrap to 0 after that beat.
REQ-023 B: o_bready SHALL be high; BRESP other than OKAY SHALL set err_code 2 and go to DONE; OKAY SHALL go to WACK.
REQ-024 WACK: o_wack SHALL be high for one cycle, then go to NEXT.
REQ-025 NEXT: SHALL increment idx; if idx equals num_lines, SHALL go to DONE, else LAUNCH.
REQ-026 The timeout counter SHALL reset on entry to R and B; reaching TIMEOUT_CYCLES without a handshake SHALL set err_code 3 and go to DONE.
REQ-027 DONE: o_done SHALL pulse for one cycle, then go to IDLE; num_lines values above MAX_LINES SHALL be clamped to MAX_LINES.
REQ-028 o_busy SHALL be high whenever the state is not IDLE.

Reset
REQ-029 While ace_areset is high at a clock edge, the FSM SHALL enter IDLE and all outputs, counters and line buffers SHALL be 0, including mid-burst; no handshake completion is required.

Structure
REQ-030 The shared package SHALL hold the state encoding, mode and err_code constants, and the OKAY/EXOKAY response constants.
REQ-031 The beat-indexed line buffer (write-by-beat, read-by-beat, full-line output) SHALL be sub-module line_beat_buffer.

Verification
REQ-032 Mode 0, base 0x1000, 2 lines, arready delayed 3 cycles -> ARADDR 0x1000 then 0x1040, ARLEN 3, two o_line_valid pulses, o_done, o_error 0.
REQ-033 Mode 2, mask all-0xFF, read data 0xA5 pattern -> written beats 0x5A pattern, WLAST on beat 3 only, one o_wack pulse.
REQ-034 Mode 1 with BRESP SLVERR -> err_code 2, o_done, no NEXT line issued.
REQ-035 R beat 1 carries RLAST -> err_code 1, o_done.
REQ-036 RVALID never asserted, TIMEOUT_CYCLES 16 -> err_code 3 at cycle 16 of R.
REQ-037 Reset asserted during W beat 2 -> all outputs 0 the next cycle; a fresh start completes normally; num_lines 0 -> o_done 2 cycles after start with no VALIDs.

Source files
------------

// File: rtl/active_burst_engine_pkg.sv
// Shared encodings for the burst engine: FSM states, operation modes,
// error codes and bus response values.
package active_burst_engine_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LAUNCH = 4'd1,
    S_AR     = 4'd2,
    S_R      = 4'd3,
    S_RACK   = 4'd4,
    S_MODIFY = 4'd5,
    S_AW     = 4'd6,
    S_W      = 4'd7,
    S_B      = 4'd8,
    S_WACK   = 4'd9,
    S_NEXT   = 4'd10,
    S_DONE   = 4'd11
  } state_t;

  localparam logic [1:0] MODE_READ  = 2'd0;
  localparam logic [1:0] MODE_WRITE = 2'd1;
  localparam logic [1:0] MODE_RMW   = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RLAST   = 2'd1;
  localparam logic [1:0] ERR_BRESP   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;

endpackage

// File: rtl/active_burst_engine_line_beat_buffer.sv
// One cache line held as beats: written beat-by-beat or loaded whole,
// read back one beat at a time or as the full line.
module line_beat_buffer #(
  parameter int DATA_W = 128,
  parameter int BEATS  = 4,
  parameter int BW     = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [BW-1:0]           wr_idx,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    ld_en,
  input  logic [BEATS*DATA_W-1:0] ld_line,
  input  logic [BW-1:0]           rd_idx,
  output logic [DATA_W-1:0]       rd_data,
  output logic [BEATS*DATA_W-1:0] line
);

  logic [BEATS-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst)        mem <= '0;
    else if (ld_en) mem <= ld_line;
    else if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];
  assign line    = mem;

endmodule

// File: rtl/active_burst_engine.sv
// Line-granular read / write / read-modify-write burst engine driving
// separate AR/R and AW/W/B channels, one line per bus transaction.
module active_burst_engine
  import active_burst_engine_pkg::*;
#(
  parameter int C_ACE_DATA_WIDTH = 128,
  parameter int C_ACE_ADDR_WIDTH = 44,
  parameter int BEATS_PER_LINE   = 4,
  parameter int MAX_LINES        = 8,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                      ace_aclk,
  input  logic                                      ace_areset,
  input  logic                                      i_start,
  input  logic [1:0]                                i_mode,
  input  logic [C_ACE_ADDR_WIDTH-1:0]               i_base_addr,
  input  logic [$clog2(MAX_LINES+1)-1:0]            i_num_lines,
  input  logic [C_ACE_DATA_WIDTH*BEATS_PER_LINE-1:0] i_wline,
  input  logic [C_ACE_DATA_WIDTH*BEATS_PER_LINE-1:0] i_xor_mask,
  output logic                                      o_arvalid,
  output logic [C_ACE_ADDR_WIDTH-1:0]               o_araddr,
  output logic [7:0]                                o_arlen,
  input  logic                                      i_arready,
  input  logic                                      i_rvalid,
  input  logic [C_ACE_DATA_WIDTH-1:0]               i_rdata,
  input  logic                                      i_rlast,
  output logic                                      o_rready,
  output logic                                      o_rack,
  output logic                                      o_awvalid,
  output logic [C_ACE_ADDR_WIDTH-1:0]               o_awaddr,
  output logic [7:0]                                o_awlen,
  input  logic                                      i_awready,
  output logic                                      o_wvalid,
  output logic [C_ACE_DATA_WIDTH-1:0]               o_wdata,
  output logic                                      o_wlast,
  input  logic                                      i_wready,
  input  logic                                      i_bvalid,
  input  logic [1:0]                                i_bresp,
  output logic                                      o_bready,
  output logic                                      o_wack,
  output logic                                      o_busy,
  output logic                                      o_done,
  output logic                                      o_error,
  output logic [1:0]                                o_err_code,
  output logic [C_ACE_DATA_WIDTH*BEATS_PER_LINE-1:0] o_line,
  output logic                                      o_line_valid,
  output logic [$clog2(MAX_LINES)-1:0]              o_line_idx,
  output logic [3:0]                                o_state
);

  localparam int A    = C_ACE_ADDR_WIDTH;
  localparam int LW   = C_ACE_DATA_WIDTH*BEATS_PER_LINE;
  localparam int NLW  = $clog2(MAX_LINES+1);
  localparam int IW   = $clog2(MAX_LINES);
  localparam int BW   = $clog2(BEATS_PER_LINE);
  localparam int BPL  = C_ACE_DATA_WIDTH/8*BEATS_PER_LINE;
  localparam int OFFW = $clog2(BPL);
  localparam int TW   = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES-1);

  state_t               state, state_nxt;
  logic [1:0]           mode_q, err_q;
  logic                 error_q;
  logic [A-1:0]         base_q, line_addr;
  logic [NLW-1:0]       num_q, idx_q, num_clamped;
  logic [LW-1:0]        mask_q, rline;
  logic [BW-1:0]        beat_q;
  logic [TW-1:0]        tmo_q;
  logic                 last_beat, tmo_hit, start_ok;
  logic [C_ACE_DATA_WIDTH-1:0] wbeat, rbuf_rd_unused;
  logic [LW-1:0]        wbuf_line_unused;

  assign start_ok    = (state == S_IDLE) && i_start;
  assign last_beat   = (beat_q == BW'(BEATS_PER_LINE-1));
  assign tmo_hit     = (tmo_q == TMO_LAST);
  assign num_clamped = (i_num_lines > NLW'(MAX_LINES)) ? NLW'(MAX_LINES) : i_num_lines;
  assign line_addr   = (base_q & ~A'(BPL-1)) + (A'(idx_q) << OFFW);

  line_beat_buffer #(.DATA_W(C_ACE_DATA_WIDTH), .BEATS(BEATS_PER_LINE)) u_rbuf (
    .clk(ace_aclk), .rst(ace_areset),
    .wr_en((state == S_R) && i_rvalid), .wr_idx(beat_q), .wr_data(i_rdata),
    .ld_en(1'b0), .ld_line('0),
    .rd_idx(beat_q), .rd_data(rbuf_rd_unused), .line(rline)
  );

  // Write line: the caller's line is captured at start; RMW overwrites it.
  line_beat_buffer #(.DATA_W(C_ACE_DATA_WIDTH), .BEATS(BEATS_PER_LINE)) u_wbuf (
    .clk(ace_aclk), .rst(ace_areset),
    .wr_en(1'b0), .wr_idx('0), .wr_data('0),
    .ld_en(start_ok || (state == S_MODIFY)),
    .ld_line((state == S_MODIFY) ? (rline ^ mask_q) : i_wline),
    .rd_idx(beat_q), .rd_data(wbeat), .line(wbuf_line_unused)
  );

  always_ff @(posedge ace_aclk) begin
    if (ace_areset) begin
      state <= S_IDLE;
      mode_q <= '0; base_q <= '0; num_q <= '0; mask_q <= '0;
      idx_q <= '0; beat_q <= '0; tmo_q <= '0; err_q <= '0; error_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (i_start) begin
          mode_q <= i_mode; base_q <= i_base_addr; num_q <= num_clamped;
          mask_q <= i_xor_mask; idx_q <= '0; beat_q <= '0;
          err_q <= ERR_NONE; error_q <= 1'b0;
        end
        S_AR: if (i_arready) begin tmo_q <= '0; beat_q <= '0; end
        S_R: begin
          if (i_rvalid) begin
            tmo_q  <= '0;
            beat_q <= beat_q + BW'(1);
            if (i_rlast != last_beat) begin
              err_q <= ERR_RLAST; error_q <= 1'b1; beat_q <= '0;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
            if (tmo_hit) begin err_q <= ERR_TIMEOUT; error_q <= 1'b1; end
          end
        end
        S_AW: if (i_awready) beat_q <= '0;
        S_W: if (i_wready) begin
          beat_q <= beat_q + BW'(1);
          if (last_beat) tmo_q <= '0;
        end
        S_B: begin
          if (i_bvalid) begin
            if (i_bresp != RESP_OKAY) begin err_q <= ERR_BRESP; error_q <= 1'b1; end
          end else begin
            tmo_q <= tmo_q + TW'(1);
            if (tmo_hit) begin err_q <= ERR_TIMEOUT; error_q <= 1'b1; end
          end
        end
        S_NEXT: idx_q <= idx_q + NLW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    o_arvalid    = 1'b0;
    o_rready     = 1'b0;
    o_rack       = 1'b0;
    o_line_valid = 1'b0;
    o_awvalid    = 1'b0;
    o_wvalid     = 1'b0;
    o_wlast      = 1'b0;
    o_bready     = 1'b0;
    o_wack       = 1'b0;
    o_done       = 1'b0;
    case (state)
      S_IDLE:   if (i_start) state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        if (num_q == '0 || mode_q == MODE_RSVD) state_nxt = S_DONE;
        else if (mode_q == MODE_WRITE)          state_nxt = S_AW;
        else                                    state_nxt = S_AR;
      end
      S_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) state_nxt = S_R;
      end
      S_R: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          if (i_rlast != last_beat) state_nxt = S_DONE;
          else if (last_beat)       state_nxt = S_RACK;
        end else if (tmo_hit) state_nxt = S_DONE;
      end
      S_RACK: begin
        o_rack = 1'b1; o_line_valid = 1'b1;
        state_nxt = (mode_q == MODE_RMW) ? S_MODIFY : S_NEXT;
      end
      S_MODIFY: state_nxt = S_AW;
      S_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) state_nxt = S_W;
      end
      S_W: begin
        o_wvalid = 1'b1; o_wlast = last_beat;
        if (i_wready && last_beat) state_nxt = S_B;
      end
      S_B: begin
        o_bready = 1'b1;
        if (i_bvalid) state_nxt = (i_bresp != RESP_OKAY) ? S_DONE : S_WACK;
        else if (tmo_hit) state_nxt = S_DONE;
      end
      S_WACK: begin o_wack = 1'b1; state_nxt = S_NEXT; end
      S_NEXT: state_nxt = (idx_q + NLW'(1) == num_q) ? S_DONE : S_LAUNCH;
      S_DONE: begin o_done = 1'b1; state_nxt = S_IDLE; end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Payload and length fields read as zero whenever their VALID is low.
  assign o_araddr   = o_arvalid ? line_addr : '0;
  assign o_arlen    = o_arvalid ? 8'(BEATS_PER_LINE-1) : 8'd0;
  assign o_awaddr   = o_awvalid ? line_addr : '0;
  assign o_awlen    = o_awvalid ? 8'(BEATS_PER_LINE-1) : 8'd0;
  assign o_wdata    = o_wvalid ? wbeat : '0;
  assign o_busy     = (state != S_IDLE);
  assign o_error    = error_q;
  assign o_err_code = err_q;
  assign o_line     = rline;
  assign o_line_idx = idx_q[IW-1:0];
  assign o_state    = state;

endmodule

// File: tb/tb_active_burst_engine.sv
// Directed bench for active_burst_engine: hand-built bus responses per scenario.
module tb_active_burst_engine;

  localparam int DW = 128, AW = 44, LW = 512;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 0, arready = 0, rvalid = 0, rlast = 0, awready = 0, wready = 0, bvalid = 0;
  logic [1:0] mode = 0, bresp = 0;
  logic [AW-1:0] base = 0;
  logic [3:0] num = 0;
  logic [LW-1:0] wline = 0, mask = 0;
  logic [DW-1:0] rdata = 0;
  logic arvalid, rready, rack, awvalid, wvalid, wlast, bready, wack, busy, done, error, line_valid;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [DW-1:0] wdata;
  logic [1:0] err_code;
  logic [LW-1:0] line;
  logic [2:0] line_idx;
  logic [3:0] state;

  int n_tests = 0, n_fail = 0;
  int lv_cnt = 0, wack_cnt = 0, ar_hs = 0, aw_hs = 0;

  active_burst_engine #(.TIMEOUT_CYCLES(16)) dut (
    .ace_aclk(clk), .ace_areset(rst), .i_start(start), .i_mode(mode),
    .i_base_addr(base), .i_num_lines(num), .i_wline(wline), .i_xor_mask(mask),
    .o_arvalid(arvalid), .o_araddr(araddr), .o_arlen(arlen), .i_arready(arready),
    .i_rvalid(rvalid), .i_rdata(rdata), .i_rlast(rlast), .o_rready(rready), .o_rack(rack),
    .o_awvalid(awvalid), .o_awaddr(awaddr), .o_awlen(awlen), .i_awready(awready),
    .o_wvalid(wvalid), .o_wdata(wdata), .o_wlast(wlast), .i_wready(wready),
    .i_bvalid(bvalid), .i_bresp(bresp), .o_bready(bready), .o_wack(wack),
    .o_busy(busy), .o_done(done), .o_error(error), .o_err_code(err_code),
    .o_line(line), .o_line_valid(line_valid), .o_line_idx(line_idx), .o_state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (line_valid)         lv_cnt   <= lv_cnt + 1;
    if (wack)               wack_cnt <= wack_cnt + 1;
    if (arvalid && arready) ar_hs    <= ar_hs + 1;
    if (awvalid && awready) aw_hs    <= aw_hs + 1;
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  function automatic logic [LW-1:0] line_pat(input int l);
    logic [LW-1:0] lp;
    for (int b = 0; b < 4; b++) lp[b*DW +: DW] = {4{32'hC0DE_0000 + 32'(l*16 + b)}};
    return lp;
  endfunction

  task automatic do_start(input logic [1:0] m, input logic [AW-1:0] a, input logic [3:0] n,
                          input logic [LW-1:0] wl, input logic [LW-1:0] mk);
    for (int w = 0; w < 10 && state != 4'd0; w++) cyc;
    mode = m; base = a; num = n; wline = wl; mask = mk; start = 1;
    cyc;
    start = 0;
  endtask

  task automatic serve_read(input logic [AW-1:0] exp_addr, input int ar_delay,
                            input logic [2:0] exp_idx, input logic [LW-1:0] rl, input string nm);
    for (int w = 0; w < 30 && !arvalid; w++) cyc;
    n_tests++;
    if (arvalid !== 1'b1) begin
      n_fail++; $display("FAIL %s ar_wait: arvalid=%0b required 1", nm, arvalid); return;
    end
    n_tests++;
    if (araddr !== exp_addr) begin n_fail++; $display("FAIL %s araddr: got %h required %h", nm, araddr, exp_addr); end
    n_tests++;
    if (arlen !== 8'd3) begin n_fail++; $display("FAIL %s arlen: got %0d required 3", nm, arlen); end
    n_tests++;
    if (line_idx !== exp_idx) begin n_fail++; $display("FAIL %s line_idx: got %0d required %0d", nm, line_idx, exp_idx); end
    for (int d = 0; d < ar_delay; d++) begin
      cyc;
      n_tests++;
      if (arvalid !== 1'b1 || araddr !== exp_addr) begin
        n_fail++; $display("FAIL %s ar_hold: arvalid=%0b araddr=%h required 1/%h", nm, arvalid, araddr, exp_addr);
      end
    end
    arready = 1; cyc; arready = 0;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1; rdata = rl[b*DW +: DW]; rlast = (b == 3);
      n_tests++;
      if (rready !== 1'b1) begin n_fail++; $display("FAIL %s rready beat%0d: got %0b required 1", nm, b, rready); end
      cyc;
    end
    rvalid = 0; rlast = 0;
    n_tests++;
    if (rack !== 1'b1 || line_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s rack/line_valid: got %0b/%0b required 1/1", nm, rack, line_valid);
    end
    n_tests++;
    if (line !== rl) begin n_fail++; $display("FAIL %s o_line: got %h required %h", nm, line, rl); end
  endtask

  task automatic serve_write(input logic [AW-1:0] exp_addr, input logic [LW-1:0] wl,
                             input logic [1:0] resp, input string nm);
    for (int w = 0; w < 30 && !awvalid; w++) cyc;
    n_tests++;
    if (awvalid !== 1'b1) begin
      n_fail++; $display("FAIL %s aw_wait: awvalid=%0b required 1", nm, awvalid); return;
    end
    n_tests++;
    if (awaddr !== exp_addr || awlen !== 8'd3) begin
      n_fail++; $display("FAIL %s aw: got %h/%0d required %h/3", nm, awaddr, awlen, exp_addr);
    end
    awready = 1; cyc; awready = 0;
    cyc;  // one stalled cycle: beat 0 must hold
    n_tests++;
    if (wvalid !== 1'b1 || wdata !== wl[DW-1:0] || wlast !== 1'b0) begin
      n_fail++; $display("FAIL %s w_stall: got v=%0b d=%h l=%0b required 1/%h/0", nm, wvalid, wdata, wlast, wl[DW-1:0]);
    end
    wready = 1;
    for (int b = 0; b < 4; b++) begin
      n_tests++;
      if (wvalid !== 1'b1 || wdata !== wl[b*DW +: DW] || wlast !== (b == 3)) begin
        n_fail++; $display("FAIL %s w_beat%0d: got v=%0b d=%h l=%0b required 1/%h/%0b",
                           nm, b, wvalid, wdata, wlast, wl[b*DW +: DW], (b == 3));
      end
      cyc;
    end
    wready = 0;
    n_tests++;
    if (bready !== 1'b1) begin n_fail++; $display("FAIL %s bready: got %0b required 1", nm, bready); end
    bvalid = 1; bresp = resp; cyc; bvalid = 0; bresp = 0;
  endtask

  task automatic wait_done(input string nm);
    for (int w = 0; w < 40 && !done; w++) cyc;
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s done: got %0b required 1", nm, done); end
  endtask

  task automatic test_reset;
    repeat (2) cyc;
    rst = 0; cyc;
    n_tests++;
    if (state !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: state=%0d busy=%0b done=%0b required 0/0/0", state, busy, done);
    end
    n_tests++;
    if (arlen !== 8'd0 || araddr !== '0 || line !== '0 || err_code !== 2'd0 || error !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: arlen=%0d araddr=%h err=%0d required 0", arlen, araddr, err_code);
    end
  endtask

  task automatic test_read_leak;
    int lv0 = lv_cnt;
    do_start(2'd0, 44'h1000, 4'd2, '0, '0);
    serve_read(44'h1000, 3, 3'd0, line_pat(0), "rl_l0");
    serve_read(44'h1040, 0, 3'd1, line_pat(1), "rl_l1");
    wait_done("rl");
    n_tests++;
    if (err_code !== 2'd0 || error !== 1'b0) begin
      n_fail++; $display("FAIL rl_err: got %0d/%0b required 0/0", err_code, error);
    end
    n_tests++;
    if (lv_cnt - lv0 !== 2) begin n_fail++; $display("FAIL rl_lv_count: got %0d required 2", lv_cnt - lv0); end
  endtask

  task automatic test_rmw;
    int wk0 = wack_cnt;
    do_start(2'd2, 44'h2000, 4'd1, '0, {LW{1'b1}});
    serve_read(44'h2000, 0, 3'd0, {64{8'hA5}}, "rmw");
    serve_write(44'h2000, {64{8'h5A}}, 2'b00, "rmw");
    n_tests++;
    if (wack !== 1'b1) begin n_fail++; $display("FAIL rmw_wack: got %0b required 1", wack); end
    wait_done("rmw");
    n_tests++;
    if (wack_cnt - wk0 !== 1 || err_code !== 2'd0) begin
      n_fail++; $display("FAIL rmw_summary: wacks=%0d err=%0d required 1/0", wack_cnt - wk0, err_code);
    end
  endtask

  task automatic test_bresp_err;
    logic [LW-1:0] wl;
    int aw0 = aw_hs;
    for (int b = 0; b < 4; b++) wl[b*DW +: DW] = {4{32'h1111_0000 + 32'(b)}};
    do_start(2'd1, 44'h3000, 4'd2, wl, '0);
    serve_write(44'h3000, wl, 2'b10, "slverr");
    wait_done("slverr");
    n_tests++;
    if (err_code !== 2'd2 || error !== 1'b1 || wack !== 1'b0) begin
      n_fail++; $display("FAIL slverr_err: got %0d/%0b/%0b required 2/1/0", err_code, error, wack);
    end
    repeat (5) cyc;
    n_tests++;
    if (aw_hs - aw0 !== 1 || state !== 4'd0) begin
      n_fail++; $display("FAIL slverr_no_next: aw=%0d state=%0d required 1/0", aw_hs - aw0, state);
    end
  endtask

  task automatic test_bad_rlast;
    int lv0 = lv_cnt;
    do_start(2'd0, 44'h4000, 4'd1, '0, '0);
    for (int w = 0; w < 30 && !arvalid; w++) cyc;
    arready = 1; cyc; arready = 0;
    rvalid = 1; rdata = 128'h1; rlast = 0; cyc;
    rdata = 128'h2; rlast = 1; cyc;
    rvalid = 0; rlast = 0;
    n_tests++;
    if (done !== 1'b1 || err_code !== 2'd1 || error !== 1'b1 || lv_cnt - lv0 !== 0) begin
      n_fail++; $display("FAIL rlast_err: done=%0b err=%0d error=%0b lv=%0d required 1/1/1/0",
                         done, err_code, error, lv_cnt - lv0);
    end
  endtask

  task automatic test_timeout;
    int n_r = 0;
    do_start(2'd0, 44'h5000, 4'd1, '0, '0);
    for (int w = 0; w < 30 && !arvalid; w++) cyc;
    arready = 1; cyc; arready = 0;
    while (state == 4'd3 && n_r < 40) begin n_r++; cyc; end
    n_tests++;
    if (n_r !== 16) begin n_fail++; $display("FAIL tmo_cycles: got %0d required 16", n_r); end
    n_tests++;
    if (done !== 1'b1 || err_code !== 2'd3 || error !== 1'b1) begin
      n_fail++; $display("FAIL tmo_err: done=%0b err=%0d error=%0b required 1/3/1", done, err_code, error);
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [LW-1:0] wl;
    int ar0, aw0;
    for (int b = 0; b < 4; b++) wl[b*DW +: DW] = {4{32'h2222_0000 + 32'(b)}};
    do_start(2'd1, 44'h6000, 4'd1, wl, '0);
    for (int w = 0; w < 30 && !awvalid; w++) cyc;
    awready = 1; cyc; awready = 0;
    wready = 1; cyc; cyc;
    n_tests++;
    if (wvalid !== 1'b1 || wdata !== wl[2*DW +: DW]) begin
      n_fail++; $display("FAIL rst_pre_beat2: got v=%0b d=%h required 1/%h", wvalid, wdata, wl[2*DW +: DW]);
    end
    rst = 1; cyc; wready = 0;
    n_tests++;
    if ({state, busy, wvalid, wdata, wlast, awvalid, awlen, line, err_code, error, done, line_idx} !== '0) begin
      n_fail++; $display("FAIL rst_mid_w: state=%0d busy=%0b wvalid=%0b wdata=%h line_nz=%0b required all 0",
                         state, busy, wvalid, wdata, |line);
    end
    rst = 0; cyc;
    do_start(2'd0, 44'h7000, 4'd1, '0, '0);
    serve_read(44'h7000, 1, 3'd0, line_pat(7), "post_rst");
    wait_done("post_rst");
    cyc;
    ar0 = ar_hs; aw0 = aw_hs;
    do_start(2'd0, 44'h8000, 4'd0, '0, '0);
    n_tests++;
    if (done !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0) begin
      n_fail++; $display("FAIL zero_lines_c1: done=%0b ar=%0b aw=%0b required 0/0/0", done, arvalid, awvalid);
    end
    cyc;
    n_tests++;
    if (done !== 1'b1 || arvalid !== 1'b0 || awvalid !== 1'b0 || ar_hs != ar0 || aw_hs != aw0) begin
      n_fail++; $display("FAIL zero_lines_c2: done=%0b ar=%0b aw=%0b required 1/0/0", done, arvalid, awvalid);
    end
  endtask

  task automatic test_reserved_mode;
    int ar0 = ar_hs, aw0 = aw_hs;
    do_start(2'd3, 44'h9000, 4'd2, '0, '0);
    wait_done("rsvd");
    n_tests++;
    if (ar_hs != ar0 || aw_hs != aw0 || err_code !== 2'd0) begin
      n_fail++; $display("FAIL rsvd_traffic: ar=%0d aw=%0d err=%0d required 0/0/0", ar_hs - ar0, aw_hs - aw0, err_code);
    end
  endtask

  task automatic test_clamp_wrap;
    int lv0 = lv_cnt;
    logic [AW-1:0] ea;
    do_start(2'd0, 44'hFFF_FFFF_FF10, 4'd12, '0, '0);
    for (int k = 0; k < 8; k++) begin
      ea = 44'hFFF_FFFF_FF00 + 44'(k*64);
      serve_read(ea, 0, 3'(k), line_pat(k + 20), "clamp");
    end
    wait_done("clamp");
    n_tests++;
    if (lv_cnt - lv0 !== 8) begin n_fail++; $display("FAIL clamp_lines: got %0d required 8", lv_cnt - lv0); end
  endtask

  initial begin
    test_reset;
    test_read_leak;
    test_rmw;
    test_bresp_err;
    test_bad_rlast;
    test_timeout;
    test_reset_mid_burst;
    test_reserved_mode;
    test_clamp_wrap;
    repeat (3) cyc;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
